// File: rtl/num_serializer.sv
// Buffers words and emits them as 2-bit symbols, MSB pair first. The first symbol appears one edge after the push; in_ready drops only when the FIFO is full.
// Defining NUM_SERIALIZER_SEP_EN inserts one num=00, num_valid=1 separator cycle after every word.
module num_serializer #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        num,
  output logic              num_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int NSYM  = WORD_W / 2;
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SEP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        num_q, num_d;
  logic              num_valid_q, num_valid_d;
  logic              word_done_q, word_done_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              last_sym;
  logic [WORD_W-1:0] head;

  assign in_ready   = (cnt_q != FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign push       = in_valid && in_ready;
  assign last_sym   = (idx_q == LAST_IDX);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
          shreg_d = head;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (!last_sym) begin
          idx_d   = idx_q + 1'b1;
          shreg_d = shreg_q << 2;
        end else begin
`ifdef NUM_SERIALIZER_SEP_EN
          state_d = SEP;
`else
          // Chain straight into the next word so there is no bubble.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = head;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
      SEP: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
          shreg_d = head;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;

    // Outputs are registered, so they are derived from the next state.
    num_d       = (state_d == SHIFT) ? shreg_d[WORD_W-1 -: 2] : 2'b00;
    num_valid_d = (state_d != IDLE);
    word_done_d = (state_d == SHIFT) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      num_q       <= 2'b00;
      num_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      word_done_q <= word_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= in_word;
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign word_done = word_done_q;
  assign busy      = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: doc/num_serializer.md
Name: num_serializer

Overview:
- Upstream feeder for the 2-bit symbol sequence detector. Takes whole words over a valid/ready handshake and buffers them in a small FIFO.
- Emits each word as a stream of 2-bit symbols on `num`, MSB pair first, one symbol per clock.
- When no symbol is due, drives `num`=2'b00, which returns the downstream detector to its idle state.

Parameters:
- WORD_W, 8: input word width. Must be even and at least 2. Symbols per word: NSYM = WORD_W/2.
- FIFO_DEPTH, 4: number of buffered words, excluding the word held in the shift register. Power of two, at least 2.

Ports:
- clk, input, 1: single clock; all state changes on posedge.
- reset, input, 1: synchronous, active-high reset.
- in_word, input, WORD_W: word to serialize.
- in_valid, input, 1: in_word is valid this cycle.
- in_ready, output, 1: FIFO can accept a word. Combinational: in_ready = !full.
- num, output, 2: current symbol; registered.
- num_valid, output, 1: num carries a real symbol (or a separator); registered.
- word_done, output, 1: one-cycle pulse, high in the same cycle as the last data symbol of a word; registered.
- busy, output, 1: high when the shift register is active or the FIFO is non-empty.

Behaviour:
- Reset (reset=1 at posedge):
  - FIFO emptied; state=IDLE.
  - num=2'b00, num_valid=0, word_done=0, busy=0.
  - A handshake in the reset cycle is ignored and no word is stored.
- Push: in_valid && in_ready at posedge writes in_word to the FIFO tail.
- FIFO rules:
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - When full, in_ready=0, so no push occurs.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- State machine:
  - IDLE: num=00, num_valid=0. If FIFO non-empty, pop the head into the shift register, set sym_idx=0, go to SHIFT.
  - SHIFT: num = shreg[WORD_W-1-2*sym_idx -: 2], num_valid=1. sym_idx increments each cycle.
  - At sym_idx==NSYM-1, word_done=1 in the same cycle. Next state:
    - SEP if SEP_EN is defined;
    - otherwise pop the next word and stay in SHIFT with sym_idx=0 if the FIFO is non-empty (no bubble);
    - otherwise go to IDLE.
  - SEP (only when SEP_EN is defined): one cycle of num=00, num_valid=1. Then pop and go to SHIFT if the FIFO is non-empty, else go to IDLE.
- Latency: a word pushed into an empty FIFO while IDLE at edge k has its first symbol on num after edge k+1. Its last symbol appears after edge k+NSYM.
- Pop condition: state==IDLE, or (SHIFT && sym_idx==NSYM-1 && SEP_EN undefined), or state==SEP; in every case the FIFO must be non-empty.
- busy = (state!=IDLE) || (count!=0).
- Reset mid-word: output stops immediately after the edge. num=00 and all buffered words are discarded.
- An in_valid held while in_ready=0 has no effect. The producer keeps the data stable until accepted.

Optional Feature:
- Macro: NUM_SERIALIZER_SEP_EN.
- Defined: after every word, one separator cycle drives num=00 with num_valid=1. This forces the downstream detector to its idle state between words, so matches never span word boundaries. Throughput is NSYM+1 cycles per word.
- Undefined: words are concatenated with no gap, so a match may span a word boundary. Throughput is NSYM cycles per word.

Test Plan:
- Reset behaviour: hold reset 2 cycles, then release with in_valid=0 -> num=00, num_valid=0, busy=0, in_ready=1.
- Single word: push 8'b01_10_11_00 at edge 0 -> num=01,10,11,00 after edges 1..4; num_valid=1 for those 4 cycles; word_done high only in the 00 cycle; IDLE after edge 5 with num=00, num_valid=0.
- Back-to-back (macro undefined): push 8'h6C then 8'h1B on consecutive cycles -> symbols 01,10,11,00,00,01,10,11 with no gap.
- Back-to-back (macro defined): same stimulus -> 01,10,11,00,00(sep),00,01,10,11,00(sep). num_valid=1 throughout the sequence; word_done high exactly twice.
- Full FIFO (DEPTH=4): hold in_valid=1 every cycle from edge 0 -> words accepted at edges 0..4; in_ready=0 after edge 4; in_ready returns to 1 after edge 5; no word lost or duplicated; pointer wrap verified over 12 words.
- Reset mid-operation: assert reset after the 2nd symbol of a word with 3 words buffered -> next cycle num=00, num_valid=0, busy=0, in_ready=1; none of the buffered words are emitted afterwards.
